ddr2_responder: RTL and testbench

- Single-clock memory responder for the frame-buffer word interface: separate write (address, data, write, waitrequest) and read (address, read, data, waitrequest) channels.
- Services the requests issued by the frame-buffer initiator from an internal word RAM, with configurable access latency.
- Used as the ddr2_sys stand-in for simulation and on-chip bring-up, and as the responder end for any future initiator on this interface.

---
 rtl/ddr2_if_pkg.sv | 28 ++
 rtl/ddr2_word_ram.sv | 33 +++
 rtl/ddr2_responder.sv | 150 +++++++++++++++
 tb/tb_ddr2_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_if_pkg.sv
// ============================================================================
//  ddr2_if_pkg
//  Shared types and constants for the frame-buffer word interface responder.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package ddr2_if_pkg;

    localparam int WORD_BYTES    = 4;
    localparam int DEPTH_DEFAULT = 640;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_BUSY = 3'd1,
        S_RD_BUSY = 3'd2,
        S_WR_DONE = 3'd3,
        S_RD_DONE = 3'd4
    } state_t;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/ddr2_word_ram.sv
// ============================================================================
//  ddr2_word_ram
//  Single-port synchronous word RAM with registered read output.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ddr2_word_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // No reset on the array or read register so the tools can map it to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr2_responder.sv
// ============================================================================
//  ddr2_responder
//  Word-RAM responder for the frame-buffer write/read channels, fixed latency.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ddr2_responder
    import ddr2_if_pkg::*;
#(
    parameter int DEPTH      = DEPTH_DEFAULT,
    parameter int AW         = 10,
    parameter int WR_LATENCY = 2,
    parameter int RD_LATENCY = 4
) (
    input  logic        ctrl_clk,
    input  logic        reset_n,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic        write,
    output logic        write_waitrequest,
    input  logic [31:0] read_addr,
    input  logic        read,
    output logic [31:0] read_data,
    output logic        read_waitrequest,
    output logic        addr_err
);

    state_t        state;
    grant_t        last_grant;
    logic [3:0]    lat_cnt;
    logic [AW-1:0] addr_q;
    logic          in_range_q;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          wr_in_range;
    logic          rd_in_range;
    logic          grant_wr;
    logic          grant_rd;
    logic          ram_we;
    logic          ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;
    logic          unused_addr_bits;

    assign wr_idx      = write_addr[AW+1:2];
    assign rd_idx      = read_addr[AW+1:2];
    assign wr_in_range = int'(wr_idx) < DEPTH;
    assign rd_in_range = int'(rd_idx) < DEPTH;

    assign unused_addr_bits = ^{write_addr[31:AW+2], read_addr[31:AW+2]};

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state == S_IDLE) begin
            if (write && read) begin
                grant_wr = (last_grant == GRANT_RD);
                grant_rd = (last_grant == GRANT_WR);
            end else begin
                grant_wr = write;
                grant_rd = read;
            end
        end
    end

    // The RAM read is launched on the grant edge so its output is settled
    // throughout RD_BUSY, even with a one-cycle read latency.
    assign ram_we   = (state == S_WR_DONE) && in_range_q;
    assign ram_re   = grant_rd && rd_in_range;
    assign ram_addr = (state == S_WR_DONE) ? addr_q : rd_idx;

    ddr2_word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (ctrl_clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (write_data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge ctrl_clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            last_grant        <= GRANT_RD;
            lat_cnt           <= 4'd0;
            addr_q            <= '0;
            in_range_q        <= 1'b0;
            write_waitrequest <= 1'b1;
            read_waitrequest  <= 1'b1;
            read_data         <= 32'h0;
            addr_err          <= 1'b0;
        end else begin
            write_waitrequest <= 1'b1;
            read_waitrequest  <= 1'b1;
            case (state)
                S_IDLE: begin
                    lat_cnt <= 4'd0;
                    if (write && read) begin
                        last_grant <= grant_wr ? GRANT_WR : GRANT_RD;
                    end
                    if (grant_wr) begin
                        state      <= S_WR_BUSY;
                        addr_q     <= wr_idx;
                        in_range_q <= wr_in_range;
                        if (!wr_in_range || (write_addr[1:0] != 2'b00)) begin
                            addr_err <= 1'b1;
                        end
                    end else if (grant_rd) begin
                        state      <= S_RD_BUSY;
                        addr_q     <= rd_idx;
                        in_range_q <= rd_in_range;
                        if (!rd_in_range || (read_addr[1:0] != 2'b00)) begin
                            addr_err <= 1'b1;
                        end
                    end
                end
                S_WR_BUSY: begin
                    if (lat_cnt == 4'(WR_LATENCY - 1)) begin
                        state             <= S_WR_DONE;
                        lat_cnt           <= 4'd0;
                        write_waitrequest <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_RD_BUSY: begin
                    if (lat_cnt == 4'(RD_LATENCY - 1)) begin
                        state            <= S_RD_DONE;
                        lat_cnt          <= 4'd0;
                        read_waitrequest <= 1'b0;
                        read_data        <= in_range_q ? ram_rdata : 32'h0;
                    end else begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                S_WR_DONE: state <= S_IDLE;
                S_RD_DONE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr2_responder.sv
// ============================================================================
//  tb_ddr2_responder
//  Self-checking bench for ddr2_responder with a read-data scoreboard.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ddr2_responder;

    localparam int DEPTH  = 640;
    localparam int AW     = 10;
    localparam int WR_LAT = 2;
    localparam int RD_LAT = 4;

    logic        ctrl_clk = 1'b0;
    logic        reset_n  = 1'b0;
    logic [31:0] write_addr = '0, write_data = '0, read_addr = '0;
    logic        write = 1'b0, read = 1'b0;
    logic        write_waitrequest, read_waitrequest, addr_err;
    logic [31:0] read_data;

    logic [31:0] write_addr2 = '0, write_data2 = '0, read_addr2 = '0;
    logic        write2 = 1'b0, read2 = 1'b0;
    logic        write_waitrequest2, read_waitrequest2, addr_err2;
    logic [31:0] read_data2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [DEPTH];
    logic        model_err     = 1'b0;
    logic        model_last_rd = 1'b1;
    logic [31:0] sb [$];

    always #5 ctrl_clk = ~ctrl_clk;

    ddr2_responder #(
        .DEPTH(DEPTH), .AW(AW), .WR_LATENCY(WR_LAT), .RD_LATENCY(RD_LAT)
    ) dut (
        .ctrl_clk          (ctrl_clk),
        .reset_n           (reset_n),
        .write_addr        (write_addr),
        .write_data        (write_data),
        .write             (write),
        .write_waitrequest (write_waitrequest),
        .read_addr         (read_addr),
        .read              (read),
        .read_data         (read_data),
        .read_waitrequest  (read_waitrequest),
        .addr_err          (addr_err)
    );

    ddr2_responder #(
        .DEPTH(DEPTH), .AW(AW), .WR_LATENCY(1), .RD_LATENCY(1)
    ) dut_fast (
        .ctrl_clk          (ctrl_clk),
        .reset_n           (reset_n),
        .write_addr        (write_addr2),
        .write_data        (write_data2),
        .write             (write2),
        .write_waitrequest (write_waitrequest2),
        .read_addr         (read_addr2),
        .read              (read2),
        .read_data         (read_data2),
        .read_waitrequest  (read_waitrequest2),
        .addr_err          (addr_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic in_range(input logic [31:0] addr);
        logic [AW-1:0] idx;
        idx = addr[AW+1:2];
        return int'(idx) < DEPTH;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        int n;
        logic [AW-1:0] idx;
        idx = addr[AW+1:2];
        if (in_range(addr)) model_mem[idx] = data;
        if (!in_range(addr) || addr[1:0] != 2'b00) model_err = 1'b1;
        write_addr = addr;
        write_data = data;
        write      = 1'b1;
        n = 0;
        while (n == 0 || (write_waitrequest && n < 50)) begin
            @(negedge ctrl_clk);
            n++;
        end
        write = 1'b0;
        check("wr_latency", n, WR_LAT + 1);
        @(negedge ctrl_clk);
        check("wr_pulse_1cyc", {31'h0, write_waitrequest}, 32'h1);
    endtask

    task automatic do_read(input logic [31:0] addr);
        int n;
        logic [AW-1:0] idx;
        logic [31:0] exp;
        idx = addr[AW+1:2];
        sb.push_back(in_range(addr) ? model_mem[idx] : 32'h0);
        if (!in_range(addr) || addr[1:0] != 2'b00) model_err = 1'b1;
        read_addr = addr;
        read      = 1'b1;
        n = 0;
        while (n == 0 || (read_waitrequest && n < 50)) begin
            @(negedge ctrl_clk);
            n++;
        end
        read = 1'b0;
        check("rd_latency", n, RD_LAT + 1);
        exp = sb.pop_front();
        check("rd_data", read_data, exp);
        @(negedge ctrl_clk);
        check("rd_pulse_1cyc", {31'h0, read_waitrequest}, 32'h1);
        check("rd_data_held", read_data, exp);
        check("addr_err", {31'h0, addr_err}, {31'h0, model_err});
    endtask

    // Simultaneous write and read; exp_wn/exp_rn are the cycles (from the
    // request) on which each waitrequest is expected low.
    task automatic do_pair(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                           input int exp_wn, input int exp_rn);
        int n, wn, rn, overlap;
        logic wr_first;
        logic [AW-1:0] wi, ri;
        n = 0; wn = 0; rn = 0; overlap = 0;
        wi = wa[AW+1:2];
        ri = ra[AW+1:2];
        wr_first = model_last_rd;
        if (wr_first) model_mem[wi] = wd;
        sb.push_back(model_mem[ri]);
        if (!wr_first) model_mem[wi] = wd;
        model_last_rd = ~wr_first;
        write_addr = wa; write_data = wd; read_addr = ra;
        write = 1'b1; read = 1'b1;
        while ((write || read) && n < 60) begin
            @(negedge ctrl_clk);
            n++;
            if (!write_waitrequest && !read_waitrequest) overlap++;
            if (write && !write_waitrequest) begin
                wn = n;
                write = 1'b0;
            end
            if (read && !read_waitrequest) begin
                rn = n;
                read = 1'b0;
                check("pair_rd_data", read_data, sb.pop_front());
            end
        end
        if (read) void'(sb.pop_front());
        write = 1'b0;
        read  = 1'b0;
        check("pair_wr_cycle", wn, exp_wn);
        check("pair_rd_cycle", rn, exp_rn);
        check("pair_overlap", overlap, 0);
        @(negedge ctrl_clk);
    endtask

    initial begin
        int n, lows, next_exp;

        reset_n = 1'b0;
        repeat (3) @(negedge ctrl_clk);
        check("rst_wr_wait", {31'h0, write_waitrequest}, 32'h1);
        check("rst_rd_wait", {31'h0, read_waitrequest}, 32'h1);
        check("rst_rd_data", read_data, 32'h0);
        check("rst_addr_err", {31'h0, addr_err}, 32'h0);
        reset_n = 1'b1;
        @(negedge ctrl_clk);

        // Tie after reset goes to write; the next tie goes to read.
        do_pair(32'h20, 32'h1111_1111, 32'h20, 3, 9);
        do_pair(32'h20, 32'h2222_2222, 32'h20, 9, 5);

        do_write(32'h10, 32'hDEAD_BEEF);
        do_read(32'h10);
        do_write(32'h14, 32'h0BAD_F00D);
        check("rd_data_held_over_wr", read_data, 32'hDEAD_BEEF);

        for (int i = 0; i < DEPTH; i++) do_write(32'(i * 4), 32'(i));
        for (int i = 0; i < DEPTH; i++) do_read(32'(i * 4));

        do_read(32'(DEPTH * 4));
        do_write(32'h13, 32'hA5A5_A5A5);
        do_read(32'h10);

        // Reset in the middle of WR_BUSY must leave word 0 untouched.
        write_addr = 32'h0; write_data = 32'h55; write = 1'b1;
        @(negedge ctrl_clk);
        reset_n = 1'b0;
        #1;
        check("midrst_wr_wait", {31'h0, write_waitrequest}, 32'h1);
        check("midrst_addr_err", {31'h0, addr_err}, 32'h0);
        write = 1'b0;
        model_err = 1'b0;
        model_last_rd = 1'b1;
        repeat (2) @(negedge ctrl_clk);
        reset_n = 1'b1;
        @(negedge ctrl_clk);
        do_read(32'h0);

        // Held write on the latency-1 instance: one completion every 3 cycles.
        write_addr2 = 32'h8; write_data2 = 32'h77; write2 = 1'b1;
        lows = 0; next_exp = 2;
        for (int c = 1; c <= 20; c++) begin
            @(negedge ctrl_clk);
            if (!write_waitrequest2) begin
                check("b2b_cycle", c, next_exp);
                next_exp += 3;
                lows++;
            end
        end
        write2 = 1'b0;
        check("b2b_count", lows, 7);
        @(negedge ctrl_clk);
        read_addr2 = 32'h8; read2 = 1'b1;
        n = 0;
        while (n == 0 || (read_waitrequest2 && n < 50)) begin
            @(negedge ctrl_clk);
            n++;
        end
        read2 = 1'b0;
        check("fast_rd_latency", n, 2);
        check("fast_rd_data", read_data2, 32'h77);
        check("fast_addr_err", {31'h0, addr_err2}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
